// File: rtl/axi_rd_master.sv
// AXI4 read-only master: turns one CPU read request into one INCR burst and streams beats back.
// Optional watchdog: define AXI_RD_TIMEOUT_EN to abort stalled bursts after TIMEOUT_CYC cycles.

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

module axi_rd_master #(
    parameter logic [`AXI_ID_BITS-1:0] MID         = '0,
    parameter int unsigned             TIMEOUT_CYC = 1023
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    // CPU request side
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    input  logic [2:0]              req_size,
    input  logic [3:0]              req_len,
    output logic                    dat_valid,
    input  logic                    dat_ready,
    output logic [31:0]             dat_data,
    output logic                    dat_last,
    output logic                    done,
    output logic [1:0]              status,
    // AXI AR channel
    output logic [`AXI_ID_BITS-1:0] ARID,
    output logic [31:0]             ARADDR,
    output logic [3:0]              ARLEN,
    output logic [2:0]              ARSIZE,
    output logic [1:0]              ARBURST,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    // AXI R channel
    input  logic [`AXI_ID_BITS-1:0] RID,
    input  logic [31:0]             RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY
);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespProto  = 2'b01;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;
    localparam logic [1:0] BurstIncr  = 2'b01;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1024) begin : g_bad_timeout
        $error("TIMEOUT_CYC must lie in 1..1024");
    end

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e                  state_q;
    logic                    arvalid_q;
    logic [`AXI_ID_BITS-1:0] arid_q;
    logic [31:0]             araddr_q;
    logic [3:0]              arlen_q;
    logic [2:0]              arsize_q;
    logic [1:0]              arburst_q;
    logic [3:0]              beat_cnt_q;
    logic [1:0]              resp_q;
    logic                    proto_q;
    logic                    done_q;
    logic [1:0]              status_q;

    logic       in_data;
    logic       ar_hs;
    logic       r_beat;
    logic       at_len;
    logic       beat_proto;
    logic       proto_next;
    logic       last_beat;
    logic [1:0] resp_merged;
    logic       wdog_fire;

    assign in_data = (state_q == StData);
    assign ar_hs   = (state_q == StAddr) && ARREADY;
    assign r_beat  = in_data && RVALID && dat_ready;
    assign at_len  = (beat_cnt_q == arlen_q);

    // Wrong ID, or RLAST disagreeing with the beat count, is a protocol error.
    assign beat_proto = (RID != MID) || (RLAST != at_len);
    assign proto_next = proto_q || beat_proto;
    // Leave on RLAST, or after len+1 beats even if the slave never signals RLAST.
    assign last_beat  = r_beat && (RLAST || at_len);

    always_comb begin
        resp_merged = RespOkay;
        if (resp_q == RespDecErr || RRESP == RespDecErr) begin
            resp_merged = RespDecErr;
        end else if (resp_q == RespSlvErr || RRESP == RespSlvErr) begin
            resp_merged = RespSlvErr;
        end
    end

`ifdef AXI_RD_TIMEOUT_EN
    localparam logic [9:0] WdogLim = 10'(TIMEOUT_CYC - 1);

    logic [9:0] wdog_q;
    logic       waiting;

    assign waiting   = (state_q == StAddr) || in_data;
    assign wdog_fire = waiting && !ar_hs && !r_beat && (wdog_q == WdogLim);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wdog_q <= '0;
        end else if (waiting && !ar_hs && !r_beat) begin
            wdog_q <= wdog_q + 10'd1;
        end else begin
            wdog_q <= '0;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= StIdle;
            arvalid_q  <= 1'b0;
            arid_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
            beat_cnt_q <= '0;
            resp_q     <= RespOkay;
            proto_q    <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= RespOkay;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        arid_q     <= MID;
                        araddr_q   <= req_addr;
                        arlen_q    <= req_len;
                        arsize_q   <= req_size;
                        arburst_q  <= BurstIncr;
                        arvalid_q  <= 1'b1;
                        beat_cnt_q <= '0;
                        resp_q     <= RespOkay;
                        proto_q    <= 1'b0;
                        state_q    <= StAddr;
                    end
                end
                StAddr: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        state_q   <= StData;
                    end else if (wdog_fire) begin
                        arvalid_q <= 1'b0;
                        status_q  <= RespDecErr;
                        done_q    <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                StData: begin
                    if (r_beat) begin
                        beat_cnt_q <= beat_cnt_q + 4'd1;
                        resp_q     <= resp_merged;
                        proto_q    <= proto_next;
                        if (last_beat) begin
                            status_q <= proto_next ? RespProto : resp_merged;
                            done_q   <= 1'b1;
                            state_q  <= StResp;
                        end
                    end else if (wdog_fire) begin
                        status_q <= RespDecErr;
                        done_q   <= 1'b1;
                        state_q  <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready = (state_q == StIdle);
    assign done      = done_q;
    assign status    = status_q;

    assign ARID    = arid_q;
    assign ARADDR  = araddr_q;
    assign ARLEN   = arlen_q;
    assign ARSIZE  = arsize_q;
    assign ARBURST = arburst_q;
    assign ARVALID = arvalid_q;

    // R channel is a zero-latency pass-through to the CPU while a burst is in flight.
    assign RREADY    = in_data && dat_ready;
    assign dat_valid = in_data && RVALID;
    assign dat_data  = in_data ? RDATA : 32'h0;
    assign dat_last  = in_data && RLAST;

endmodule
